// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, 3-sample majority vote at mid-bit,
// valid/ready byte output with single-cycle framing and overrun pulses.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       rx_tick,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int KW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [KW-1:0] K_V0   = KW'(M - 1);
    localparam logic [KW-1:0] K_V1   = KW'(M);
    localparam logic [KW-1:0] K_DEC  = KW'(M + 1);
    localparam logic [KW-1:0] K_LAST = KW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [KW-1:0]          r_k;
    logic [KW-1:0]          w_k_nxt;
    logic [KW-1:0]          w_k_inc;
    logic [2:0]             r_bit;
    logic [2:0]             w_bit_nxt;
    logic [7:0]             r_shift;
    logic [7:0]             w_shift_nxt;
    logic                   r_v0;
    logic                   r_v1;
    logic                   w_vote;
    logic                   w_done;
    logic                   w_ferr;
    logic                   w_load;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign w_rx_s  = r_sync[SYNC_STAGES-1];
    // Third vote sample is the live synchronised value on the decision tick.
    assign w_vote  = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);
    assign w_k_inc = (r_k == K_LAST) ? '0 : r_k + KW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_bit   <= '0;
            r_shift <= 8'h00;
            r_v0    <= 1'b1;
            r_v1    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            if (rx_tick && r_k == K_V0) r_v0 <= w_rx_s;
            if (rx_tick && r_k == K_V1) r_v1 <= w_rx_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_tick && !w_rx_s) begin
                    w_state_nxt = S_START;
                    w_k_nxt     = '0;
                end
            end
            S_START: begin
                if (rx_tick) begin
                    w_k_nxt = w_k_inc;
                    if (r_k == K_DEC && w_vote) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_k == K_LAST) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    w_k_nxt = w_k_inc;
                    if (r_k == K_DEC) w_shift_nxt = {w_vote, r_shift[7:1]};
                    if (r_k == K_LAST) begin
                        if (r_bit == 3'd7) w_state_nxt = S_STOP;
                        else               w_bit_nxt   = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid-stop-bit so the next start edge is caught early.
                if (rx_tick) begin
                    w_k_nxt = w_k_inc;
                    if (r_k == K_DEC) begin
                        if (w_vote) begin
                            w_state_nxt = S_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT_HIGH;
                            w_ferr      = 1'b1;
                        end
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_tick && w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load = w_done && (!r_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= w_done && r_valid && !rx_ready;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_ferr;
    assign overrun_err = r_ovr;
    assign rx_busy     = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven at 64 clk per bit
// (tick every 4 clk, 16 ticks per bit); a monitor pops expected bytes on each transfer.
module tb_uart_rx;

    localparam int OS  = 16;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         seen_ferr = 0;
    int         seen_ovr = 0;
    int         vld_run = 0;
    int         last_run = 0;
    logic       hold_chk = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] mon_exp;
    int         tc = 0;

    uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_tick    (rx_tick),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tc = (tc + 1) % 4;
            rx_tick = (tc == 0);
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (hold_chk) begin
            check(rx_valid === 1'b1, "hold_valid", 32'(rx_valid), 32'd1);
            check(rx_data === hold_data, "hold_data", 32'(rx_data), 32'(hold_data));
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            check(exp_q.size() > 0, "byte_expected", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check(rx_data === mon_exp, "rx_data", 32'(rx_data), 32'(mon_exp));
            end
        end
        if (frame_err === 1'b1) seen_ferr++;
        if (overrun_err === 1'b1) seen_ovr++;
        if (rx_valid === 1'b1) begin
            vld_run++;
        end else if (vld_run != 0) begin
            last_run = vld_run;
            vld_run  = 0;
        end
        hold_chk  = rst_n && rx_valid && !rx_ready;
        hold_data = rx_data;
    end

    task automatic drive(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit, input int cut_bit);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == cut_bit) begin
                drive(b[i], BIT / 2);
                return;
            end
            if (i == glitch_bit) begin
                drive(b[i], 32);
                drive(1'b0, 4);
                drive(b[i], 28);
            end else begin
                drive(b[i], BIT);
            end
        end
        drive(stop_v, BIT);
    endtask

    task automatic end_checks(input string tag);
        check(seen_ferr == exp_ferr, {tag, "_frame_err_count"}, 32'(seen_ferr), 32'(exp_ferr));
        check(seen_ovr == exp_ovr, {tag, "_overrun_count"}, 32'(seen_ovr), 32'(exp_ovr));
        check(exp_q.size() == 0, {tag, "_bytes_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(rx_data === 8'h00, {tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check(rx_valid === 1'b0, {tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check(rx_busy === 1'b0, {tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
        check(frame_err === 1'b0, {tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check(overrun_err === 1'b0, {tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
    endtask

    logic [7:0] rb;
    bit         sbad;
    int         gl;
    int         to;
    int         nt;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 20);

        // Clean byte with the consumer always ready
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, -1, -1);
            begin
                repeat (200) @(posedge clk);
                @(negedge clk);
                check(rx_busy === 1'b1, "t1_busy_mid_frame", 32'(rx_busy), 32'd1);
            end
        join
        drive(1'b1, BIT);
        check(rx_busy === 1'b0, "t1_busy_after", 32'(rx_busy), 32'd0);
        check(last_run == 1, "t1_valid_width", 32'(last_run), 32'd1);
        end_checks("t1");

        // Back-to-back frames with no consumer: second byte overruns
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        exp_ovr++;
        send_frame(8'h3C, 1'b1, -1, -1);
        send_frame(8'hC3, 1'b1, -1, -1);
        drive(1'b1, BIT);
        check(rx_valid === 1'b1, "t2_valid_held", 32'(rx_valid), 32'd1);
        check(rx_data === 8'h3C, "t2_data_kept", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        @(negedge clk);
        check(rx_valid === 1'b0, "t2_valid_fall", 32'(rx_valid), 32'd0);
        @(posedge clk);
        #1;
        end_checks("t2");

        // False start, then a single-sample glitch inside a data bit
        rx_ready = 1'b1;
        drive(1'b0, 4);
        drive(1'b1, 12 * BIT);
        check(rx_busy === 1'b0, "t3_false_start_idle", 32'(rx_busy), 32'd0);
        end_checks("t3a");
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 3, -1);
        drive(1'b1, BIT);
        end_checks("t3b");

        // Low stop bit followed by a break, then recovery
        send_frame(8'h55, 1'b0, -1, -1);
        exp_ferr++;
        drive(1'b0, 3 * BIT);
        drive(1'b1, BIT);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, -1);
        drive(1'b1, BIT);
        end_checks("t4");

        // Reset in the middle of data bit 4
        send_frame(8'h12, 1'b1, -1, 4);
        @(negedge clk);
        check(rx_busy === 1'b1, "t5_busy_before_reset", 32'(rx_busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_after_reset");
        @(posedge clk);
        #1;
        drive(1'b1, 2 * BIT);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, -1, -1);
        drive(1'b1, BIT);
        end_checks("t5");

        // Transfer of the held byte lands on the same clock as the next STOP decision
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h7E);
        send_frame(8'h11, 1'b1, -1, -1);
        drive(1'b1, 32);
        check(rx_valid === 1'b1, "t6_first_held", 32'(rx_valid), 32'd1);
        fork
            send_frame(8'h7E, 1'b1, -1, -1);
            begin
                to = 0;
                nt = 0;
                @(negedge clk);
                while (rx_busy !== 1'b1 && to < 200) begin
                    @(negedge clk);
                    to++;
                end
                check(to < 200, "t6_start_detect", 32'(to), 32'd200);
                if (to < 200) begin
                    // Start detected on the tick before this negedge; STOP decides 154 ticks later.
                    while (nt < 153) begin
                        @(posedge clk);
                        if (rx_tick) nt++;
                    end
                    #1;
                    repeat (3) @(posedge clk);
                    #1;
                    rx_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    rx_ready = 1'b0;
                    @(negedge clk);
                    check(rx_valid === 1'b1, "t6_valid_stays", 32'(rx_valid), 32'd1);
                    check(rx_data === 8'h7E, "t6_new_data", 32'(rx_data), 32'h7E);
                end
            end
        join
        drive(1'b1, BIT);
        check(seen_ovr == exp_ovr, "t6_no_overrun", 32'(seen_ovr), 32'(exp_ovr));
        rx_ready = 1'b1;
        drive(1'b1, 4);
        end_checks("t6");

        // Random bytes, random gaps, occasional glitches and bad stop bits
        rx_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            rb   = 8'($urandom_range(0, 255));
            sbad = ($urandom_range(0, 4) == 0);
            gl   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            if (sbad) exp_ferr++;
            else      exp_q.push_back(rb);
            send_frame(rb, !sbad, gl, -1);
            drive(1'b1, int'($urandom_range(8, 40)));
        end
        drive(1'b1, BIT);
        end_checks("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
